// File: rtl/nes_joy_pkg.sv
// Shared constants for the NES joypad serializer.
// Button bit indices, read counter width and saturation value.
package nes_joy_pkg;

  localparam int c_cnt_w = 4;

  typedef logic [c_cnt_w-1:0] joy_cnt_t;

  localparam joy_cnt_t c_read_sat = 4'd8;

  localparam int c_btn_a      = 0;
  localparam int c_btn_b      = 1;
  localparam int c_btn_select = 2;
  localparam int c_btn_start  = 3;
  localparam int c_btn_up     = 4;
  localparam int c_btn_down   = 5;
  localparam int c_btn_left   = 6;
  localparam int c_btn_right  = 7;

endpackage

// File: rtl/nes_joy_input_filter.sv
// 2-FF synchronizer, stability filter and rising-edge pulse.
// Ports: i_clk, i_rstn, i_in (async) -> o_level, o_rise.
module nes_joy_input_filter #(
  parameter int c_filter_cycles = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_in,
  output logic o_level,
  output logic o_rise
);

  localparam logic [3:0] c_lim = 4'(c_filter_cycles - 1);

  logic       s1;
  logic       s2;
  logic       lvl_q;
  logic [3:0] cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      lvl_q   <= 1'b0;
      o_level <= 1'b0;
      cnt     <= '0;
    end else begin
      s1    <= i_in;
      s2    <= s1;
      lvl_q <= o_level;
      // accept only after s2 disagreed for c_filter_cycles in a row
      if (s2 != o_level) begin
        if (cnt == c_lim) begin
          o_level <= s2;
          cnt     <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign o_rise = o_level & ~lvl_q;

endmodule

// File: rtl/nes_joypad_serializer.sv
// Two-port NES controller (CD4021) emulation on the USB core clock.
// Ports: i_btn0/1 buttons, i_joy_strobe latch, i_joy_clk shift clocks,
// o_joy_data serial bits, o_read_cnt0/1 accepted shifts (sat. 8).
module nes_joypad_serializer
  import nes_joy_pkg::*;
#(
  parameter int   c_filter_cycles = 2,
  parameter logic c_fill_bit      = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [7:0]         i_btn0,
  input  logic [7:0]         i_btn1,
  input  logic               i_joy_strobe,
  input  logic [1:0]         i_joy_clk,
  output logic [1:0]         o_joy_data,
  output logic [c_cnt_w-1:0] o_read_cnt0,
  output logic [c_cnt_w-1:0] o_read_cnt1
);

  // bit 0 = strobe, bits 2:1 = port clocks
  logic [2:0] lvl;
  logic [2:0] rise;
  logic       unused_ok;

  logic [7:0] btn [2];
  logic [7:0] sr  [2];
  joy_cnt_t   cnt [2];

  assign btn[0] = i_btn0;
  assign btn[1] = i_btn1;

  nes_joy_input_filter #(
    .c_filter_cycles(c_filter_cycles)
  ) u_strobe (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_in   (i_joy_strobe),
    .o_level(lvl[0]),
    .o_rise (rise[0])
  );

  assign unused_ok = ^{lvl[2:1], rise[0]};

  for (genvar gp = 0; gp < 2; gp++) begin : g_port
    nes_joy_input_filter #(
      .c_filter_cycles(c_filter_cycles)
    ) u_clk (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_in   (i_joy_clk[gp]),
      .o_level(lvl[gp+1]),
      .o_rise (rise[gp+1])
    );

    // load has priority; edges while latched are dropped
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        sr[gp]  <= 8'h00;
        cnt[gp] <= '0;
      end else if (lvl[0]) begin
        sr[gp]  <= btn[gp];
        cnt[gp] <= '0;
      end else if (rise[gp+1]) begin
        sr[gp] <= {c_fill_bit, sr[gp][7:1]};
        if (cnt[gp] != c_read_sat) begin
          cnt[gp] <= cnt[gp] + joy_cnt_t'(1);
        end
      end
    end

    assign o_joy_data[gp] = sr[gp][0];
  end

  assign o_read_cnt0 = cnt[0];
  assign o_read_cnt1 = cnt[1];

endmodule
